// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters ps2_clk/ps2_data, deframes
// 11-bit frames, drops E0 prefixes and F0 break sequences, and presents each make code
// on key_pressed with a one-cycle key_flag pulse.
// Optional build macro PS2_PARITY_CHECK_EN: when defined, frames failing odd parity
// are rejected with frame_err; otherwise the parity bit is ignored.
module ps2_key_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_pressed,
  output logic       key_flag,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FiltW-1:0] FiltMax = FiltW'(FILTER_LEN - 1);
  localparam logic [TmoW-1:0]  TmoMax  = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StData, StParity, StStop, StDecode} state_e;

  state_e           state_q, state_d;
  logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic             filt_clk_q, filt_clk_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             break_q, break_d;
  logic [7:0]       key_q, key_d;
  logic             flag_q, flag_d;
  logic             err_q, err_d;
  logic             sample_evt;
  logic             in_frame;
  logic             tmo_hit;
  logic             parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q, parity_d;
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  // Synchronizers and clock glitch filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_clk_q) begin
      if (filt_cnt_q == FiltMax) begin
        filt_clk_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  assign sample_evt = filt_clk_q & ~filt_clk_d;
  assign in_frame   = (state_q == StData) || (state_q == StParity) || (state_q == StStop);
  // A sample event in the expiry cycle takes priority over the timeout.
  assign tmo_hit    = in_frame && (tmo_cnt_q == TmoMax) && !sample_evt;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (sample_evt && !data_sync_q) state_d = StData;
      end
      StData: begin
        if (sample_evt) begin
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StParity: begin
        if (sample_evt) state_d = StStop;
        else if (tmo_hit) state_d = StIdle;
      end
      StStop: begin
        if (sample_evt) state_d = (data_sync_q && parity_ok) ? StDecode : StIdle;
        else if (tmo_hit) state_d = StIdle;
      end
      StDecode: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Frame datapath: bit counter, shift register, timeout counter, parity capture.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_cnt_d = '0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d  = parity_q;
`endif
    if (in_frame && !sample_evt && !tmo_hit) tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    case (state_q)
      StIdle: bit_cnt_d = 3'd0;
      StData: begin
        if (sample_evt) begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
`ifdef PS2_PARITY_CHECK_EN
      StParity: begin
        if (sample_evt) parity_d = data_sync_q;
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_cnt_q <= '0;
      break_q   <= 1'b0;
      key_q     <= '0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_cnt_q <= tmo_cnt_d;
      break_q   <= break_d;
      key_q     <= key_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Output logic: decode is resolved at the stop sample so key_flag and key_pressed
  // update together while the FSM sits in DECODE.
  always_comb begin
    key_d   = key_q;
    flag_d  = 1'b0;
    err_d   = 1'b0;
    break_d = break_q;
    if (tmo_hit) begin
      err_d = 1'b1;
    end else if ((state_q == StStop) && sample_evt) begin
      if (!data_sync_q || !parity_ok) begin
        err_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        break_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        break_d = break_q;
      end else if (break_q) begin
        break_d = 1'b0;
      end else begin
        key_d  = shift_q;
        flag_d = 1'b1;
      end
    end
  end

  assign key_pressed = key_q;
  assign key_flag    = flag_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
Upstream stage of the convolution controller. Receives PS/2 keyboard frames on ps2_clk/ps2_data, filters and validates them, and discards break (release) sequences and E0 prefixes. Each valid make code is presented as key_pressed with a one-cycle key_flag pulse, matching what the controller expects on its key_pressed/key_flag inputs (0x16/0x1E/0x26 hold keys, 0x15/0x1D/0x24 kernel-select keys).

Parameters:
FILTER_LEN, 4, consecutive identical synchronized samples required before the filtered ps2_clk changes level
TIMEOUT_CYCLES, 50000, clk cycles allowed between bit sample events inside a frame before abort (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
ps2_clk  input  1  asynchronous PS/2 clock from keyboard, idle high
ps2_data  input  1  asynchronous PS/2 data from keyboard, idle high
key_pressed  output  8  last accepted make code; held until the next accepted code
key_flag  output  1  one-cycle pulse: key_pressed was updated this cycle
frame_err  output  1  one-cycle pulse: frame aborted (bad start/stop, timeout, parity when enabled)
busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset values: key_pressed=0x00, key_flag=0, frame_err=0, busy=0, break_pending=0, shift register=0, filtered clock=1, filter counter=0, timeout counter=0, FSM=IDLE.
- Input conditioning: ps2_clk and ps2_data each pass through 2-flop synchronizers. The filtered clock changes level only after the synchronized ps2_clk has differed from it for FILTER_LEN consecutive cycles. Pulses shorter than FILTER_LEN cycles are ignored.
- Sample event: a 1-to-0 transition of the filtered clock. Data is taken from the synchronized ps2_data in that same cycle.
- FSM states:
  - IDLE: on a sample event, data=0 -> DATA with bit count 0; data=1 -> stay in IDLE, no error.
  - DATA: each sample event shifts data in LSB first. After the 8th bit -> PARITY.
  - PARITY: a sample event captures the parity bit -> STOP.
  - STOP: on a sample event, data=1 -> DECODE; data=0 -> IDLE with a frame_err pulse.
  - DECODE: one cycle, then unconditionally -> IDLE.
- DECODE rules, applied to the received code:
  - code=0xF0: set break_pending; no flag.
  - code=0xE0: no flag; break_pending unchanged.
  - otherwise, break_pending=1: clear break_pending; no flag (release suppressed).
  - otherwise, break_pending=0: key_pressed<=code and key_flag=1 in the same cycle.
- Latency: key_flag is high exactly on the cycle after the cycle containing the stop-bit sample event.
- Timeout: the counter clears on every sample event and while in IDLE, and increments in DATA/PARITY/STOP. Reaching TIMEOUT_CYCLES-1 forces IDLE with one frame_err pulse. break_pending is unchanged.
- A sample event in the same cycle as timeout expiry: the event wins, the counter clears, and no error is raised.
- busy = (state != IDLE), registered with the state.
- A reset mid-frame aborts the frame with no flag and no error, and clears break_pending.
- key_flag and frame_err are never high in the same cycle.

Optional Feature:
PS2_PARITY_CHECK_EN
- Defined: in STOP, odd parity over the 8 data bits plus the parity bit is checked. On a mismatch the FSM goes to IDLE with a frame_err pulse in place of DECODE; no flag, break_pending unchanged.
- Undefined: the parity bit is sampled and discarded, and frames with bad parity are decoded normally.

Test Plan:
- Frame 0x16, parity=0, stop=1, bit period 2000 clk -> one key_flag pulse with key_pressed=0x16, one cycle after the stop sample; busy low afterwards.
- Sequence 0x1E, then F0, then 1E -> exactly one key_flag (0x1E). key_pressed stays 0x1E and break_pending is 0 at the end.
- Sequence E0, then 0x15 -> a single key_flag with key_pressed=0x15. Sequence E0 F0 15 -> no flag.
- Frame 0x24 with stop=0 -> one frame_err pulse, no key_flag, key_pressed unchanged; a following valid 0x24 frame -> key_flag.
- Five bits sent, then the bus idles for TIMEOUT_CYCLES -> frame_err pulse and busy falls; a subsequent 0x26 frame is accepted. A 3-cycle low glitch on ps2_clk in IDLE -> no state change.
- Frame 0x1D with flipped parity -> with PS2_PARITY_CHECK_EN: frame_err, no flag; without it: key_flag with 0x1D.
